multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle MIPS control unit: the sequential successor to the single-cycle decoder. A registered FSM sequences each instruction through fetch, decode, execute, memory and writeback. It emits per-cycle datapath controls, stalls on a memory-ready handshake, flags illegal encodings, and counts retired instructions. It sits between the instruction register (OP/funct) and the multi-cycle datapath (PC, IR, register file, ALU, unified memory).

## Interface
- ENABLE_ADDI, 1: 1 = ADDI (001000) supported; 0 = ADDI is illegal
- ENABLE_J, 1: 1 = J (000010) supported; 0 = J is illegal
- CNT_W, 16: width of the retired-instruction counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- OP  in  6  opcode from IR; sampled only in DECODE
- funct  in  6  function field from IR; sampled only in DECODE
- mem_ready  in  1  memory handshake; access completes in a cycle where it is 1
- IorD, Mem_RE, DM_WE, IR_WE, PC_WE, Branch, Reg_WE, REG_Dst, MEM_to_REG, ALU_srcA  out  1 each  datapath controls
- ALU_srcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- ALU_OP  out  2  00 add, 01 sub, 10 funct-decoded
- PC_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- illegal  out  1  one-cycle pulse on an undecodable instruction
- retire  out  1  one-cycle pulse on instruction completion
- instr_cnt  out  CNT_W  retired-instruction count
- state  out  4  current state encoding (debug)

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Encodings 12–15 go to FETCH on the next edge with no outputs asserted.
- Outputs are a Moore decode of `state`. Exceptions are the mem_ready-qualified enables, plus illegal and retire as noted. Any output not listed for a state is 0.
- FETCH: Mem_RE=1, ALU_srcB=01, IR_WE=PC_WE=mem_ready. Hold while mem_ready=0; go to DECODE when it is 1.
- DECODE: ALU_srcB=11, ALU_OP=00. Next state by OP:
  - 000000 with funct[5]=1 goes to EXECUTE.
  - 100011 (LW) or 101011 (SW) goes to MEMADR.
  - 000100 goes to BRANCH.
  - 001000 goes to ADDIEX if ENABLE_ADDI, else illegal.
  - 000010 goes to JUMP if ENABLE_J, else illegal.
  - Anything else, including R-type with funct[5]=0, is illegal.
- Illegal: illegal=1 in DECODE that cycle, next state FETCH, no retire, counter unchanged.
- MEMADR: ALU_srcA=1, ALU_srcB=10. Goes to MEMRD for LW, MEMWR for SW, using the OP latched in DECODE.
- MEMRD: IorD=1, Mem_RE=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: MEM_to_REG=1, Reg_WE=1, retire=1. Goes to FETCH.
- MEMWR: IorD=1, DM_WE=1 held for the whole wait. When mem_ready=1: retire=1, go to FETCH.
- EXECUTE: ALU_srcA=1, ALU_OP=10. Goes to ALUWB.
- ALUWB: REG_Dst=1, Reg_WE=1, retire=1. Goes to FETCH.
- BRANCH: ALU_srcA=1, ALU_OP=01, PC_src=01, Branch=1, retire=1. Goes to FETCH.
- ADDIEX: ALU_srcA=1, ALU_srcB=10. Goes to ADDIWB. ADDIWB: Reg_WE=1, retire=1. Goes to FETCH.
- JUMP: PC_src=10, PC_WE=1, retire=1. Goes to FETCH.
- instr_cnt increments by 1 on every cycle with retire=1. It is modulo 2^CNT_W: all-ones wraps to 0.

## Timing
- While rst=1: state=FETCH, instr_cnt=0, latched OP=0. IR_WE, PC_WE, DM_WE, Reg_WE, illegal and retire are forced to 0 regardless of mem_ready. Other outputs show the FETCH decode (Mem_RE=1, ALU_srcB=01).
- Reset asserted mid-instruction: the instruction is abandoned immediately and asynchronously. No retire, counter cleared.
- Cycles per instruction with mem_ready held at 1: R-type 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3, illegal 2. Each zero cycle of mem_ready in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in every other state.
- OP/funct are sampled only on the DECODE→next edge. Changes at any other time have no effect.

## Test plan
- Reset then R-type: rst pulse, OP=000000, funct=100000, mem_ready=1 → states 0,1,6,7,0. Reg_WE=REG_Dst=1 only in state 7, retire one pulse, instr_cnt=1.
- LW with memory stall: OP=100011, mem_ready low 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0. Mem_RE=IorD=1 throughout state 3. Total 7 cycles, instr_cnt +1.
- SW: OP=101011, mem_ready=1 → DM_WE=1 only in state 5, Reg_WE never 1, retire in state 5, 4 cycles.
- BEQ then J: OP=000100 gives state 8 with ALU_OP=01, Branch=1, PC_src=01. OP=000010 gives state 11 with PC_WE=1, PC_src=10. instr_cnt +2.
- Illegal: OP=111111, then OP=000000/funct=000000, then ENABLE_J=0 with OP=000010. Each gives illegal=1 in DECODE, return to FETCH, instr_cnt unchanged.
- Wrap and reset mid-flight: CNT_W=4, retire 16 R-types → instr_cnt=0. Assert rst in MEMRD → state=0 and instr_cnt=0 immediately, no retire.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control-unit bundle between the IR/memory side and the multi-cycle datapath.
// master = control unit, slave = datapath/IR side.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 16
);
    logic [5:0]       OP;
    logic [5:0]       funct;
    logic             mem_ready;

    logic             IorD;
    logic             Mem_RE;
    logic             DM_WE;
    logic             IR_WE;
    logic             PC_WE;
    logic             Branch;
    logic             Reg_WE;
    logic             REG_Dst;
    logic             MEM_to_REG;
    logic             ALU_srcA;
    logic [1:0]       ALU_srcB;
    logic [1:0]       ALU_OP;
    logic [1:0]       PC_src;
    logic             illegal;
    logic             retire;
    logic [CNT_W-1:0] instr_cnt;
    logic [3:0]       state;

    modport master (
        input  OP, funct, mem_ready,
        output IorD, Mem_RE, DM_WE, IR_WE, PC_WE, Branch, Reg_WE, REG_Dst, MEM_to_REG,
               ALU_srcA, ALU_srcB, ALU_OP, PC_src, illegal, retire, instr_cnt, state
    );

    modport slave (
        output OP, funct, mem_ready,
        input  IorD, Mem_RE, DM_WE, IR_WE, PC_WE, Branch, Reg_WE, REG_Dst, MEM_to_REG,
               ALU_srcA, ALU_srcB, ALU_OP, PC_src, illegal, retire, instr_cnt, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready, flags illegal encodings and counts retired instructions.
module multicycle_control #(
    parameter bit          ENABLE_ADDI = 1'b1,
    parameter bit          ENABLE_J    = 1'b1,
    parameter int unsigned CNT_W       = 16
) (
    input logic                 clk,
    input logic                 rst,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    state_e           state_q, state_d;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] cnt_q;

    logic       iord, mem_re, dm_we, ir_we, pc_we, branch, reg_we, reg_dst, mem_to_reg;
    logic       alu_src_a, illegal, retire;
    logic [1:0] alu_src_b, alu_op, pc_src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                op_q <= bus.OP;
            end
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = StFetch;
        iord       = 1'b0;
        mem_re     = 1'b0;
        dm_we      = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        branch     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        illegal    = 1'b0;
        retire     = 1'b0;

        case (state_q)
            StFetch: begin
                mem_re    = 1'b1;
                alu_src_b = 2'b01;
                ir_we     = bus.mem_ready;
                pc_we     = bus.mem_ready;
                state_d   = bus.mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                alu_src_b = 2'b11;
                case (bus.OP)
                    OpRtype:    if (bus.funct[5]) state_d = StExecute;
                                else illegal = 1'b1;
                    OpLw, OpSw: state_d = StMemAdr;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     if (ENABLE_ADDI) state_d = StAddiEx;
                                else illegal = 1'b1;
                    OpJ:        if (ENABLE_J) state_d = StJump;
                                else illegal = 1'b1;
                    default:    illegal = 1'b1;
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // Only LW/SW reach here, so anything but LW is a store.
                state_d   = (op_q == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                iord    = 1'b1;
                mem_re  = 1'b1;
                state_d = bus.mem_ready ? StMemWb : StMemRd;
            end
            StMemWb: begin
                mem_to_reg = 1'b1;
                reg_we     = 1'b1;
                retire     = 1'b1;
            end
            StMemWr: begin
                iord    = 1'b1;
                dm_we   = 1'b1;
                retire  = bus.mem_ready;
                state_d = bus.mem_ready ? StFetch : StMemWr;
            end
            StExecute: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_dst = 1'b1;
                reg_we  = 1'b1;
                retire  = 1'b1;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
                retire    = 1'b1;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_we = 1'b1;
                retire = 1'b1;
            end
            StJump: begin
                pc_src = 2'b10;
                pc_we  = 1'b1;
                retire = 1'b1;
            end
            default: state_d = StFetch;
        endcase

        // Write enables and pulses must stay quiet while reset is held.
        if (rst) begin
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            dm_we   = 1'b0;
            reg_we  = 1'b0;
            illegal = 1'b0;
            retire  = 1'b0;
        end
    end

    assign bus.IorD       = iord;
    assign bus.Mem_RE     = mem_re;
    assign bus.DM_WE      = dm_we;
    assign bus.IR_WE      = ir_we;
    assign bus.PC_WE      = pc_we;
    assign bus.Branch     = branch;
    assign bus.Reg_WE     = reg_we;
    assign bus.REG_Dst    = reg_dst;
    assign bus.MEM_to_REG = mem_to_reg;
    assign bus.ALU_srcA   = alu_src_a;
    assign bus.ALU_srcB   = alu_src_b;
    assign bus.ALU_OP     = alu_op;
    assign bus.PC_src     = pc_src;
    assign bus.illegal    = illegal;
    assign bus.retire     = retire;
    assign bus.instr_cnt  = cnt_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: two configurations driven in lockstep,
// each tracked by an instruction-path reference model.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       mem_ready;

    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(16)) bus_a ();
    multicycle_control_if #(.CNT_W(4))  bus_b ();

    assign bus_a.OP = op;
    assign bus_a.funct = funct;
    assign bus_a.mem_ready = mem_ready;
    assign bus_b.OP = op;
    assign bus_b.funct = funct;
    assign bus_b.mem_ready = mem_ready;

    multicycle_control #(.ENABLE_ADDI(1'b1), .ENABLE_J(1'b1), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    multicycle_control #(.ENABLE_ADDI(1'b0), .ENABLE_J(1'b0), .CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction classes: 0 illegal, 1 R, 2 LW, 3 SW, 4 BEQ, 5 ADDI, 6 J
    function automatic int classify(input logic [5:0] o, input logic [5:0] f,
                                    input bit ea, input bit ej);
        if (o == 6'b000000) return f[5] ? 1 : 0;
        if (o == 6'b100011) return 2;
        if (o == 6'b101011) return 3;
        if (o == 6'b000100) return 4;
        if (o == 6'b001000) return ea ? 5 : 0;
        if (o == 6'b000010) return ej ? 6 : 0;
        return 0;
    endfunction

    // Expected controls for a state, packed in a fixed order.
    function automatic logic [17:0] exp_ctrl(input int s, input bit mr, input bit ill,
                                             input bit r);
        logic iord, mre, dmwe, irwe, pcwe, br, regwe, regdst, m2r, srca, illg, ret;
        logic [1:0] srcb, aop, pcs;
        {iord, mre, dmwe, irwe, pcwe, br, regwe, regdst, m2r, srca, illg, ret} = '0;
        srcb = 2'd0; aop = 2'd0; pcs = 2'd0;
        case (s)
            0:  begin mre = 1; srcb = 2'd1; irwe = mr; pcwe = mr; end
            1:  begin srcb = 2'd3; illg = ill; end
            2:  begin srca = 1; srcb = 2'd2; end
            3:  begin iord = 1; mre = 1; end
            4:  begin m2r = 1; regwe = 1; ret = 1; end
            5:  begin iord = 1; dmwe = 1; ret = mr; end
            6:  begin srca = 1; aop = 2'd2; end
            7:  begin regdst = 1; regwe = 1; ret = 1; end
            8:  begin srca = 1; aop = 2'd1; pcs = 2'd1; br = 1; ret = 1; end
            9:  begin srca = 1; srcb = 2'd2; end
            10: begin regwe = 1; ret = 1; end
            11: begin pcs = 2'd2; pcwe = 1; ret = 1; end
            default: ;
        endcase
        if (r) {irwe, pcwe, dmwe, regwe, illg, ret} = '0;
        return {iord, mre, dmwe, irwe, pcwe, br, regwe, regdst, m2r, srca,
                srcb, aop, pcs, illg, ret};
    endfunction

    // Reference model: each instruction is a list of states walked in order.
    int          path [2][8];
    int          plen [2];
    int          pidx [2];
    int unsigned cnt  [2];
    int unsigned mask [2];
    bit          en_addi [2];
    bit          en_j    [2];

    task automatic set_path(input int k, input int c);
        plen[k] = 2;
        case (c)
            1: begin path[k][2] = 6; path[k][3] = 7; plen[k] = 4; end
            2: begin path[k][2] = 2; path[k][3] = 3; path[k][4] = 4; plen[k] = 5; end
            3: begin path[k][2] = 2; path[k][3] = 5; plen[k] = 4; end
            4: begin path[k][2] = 8; plen[k] = 3; end
            5: begin path[k][2] = 9; path[k][3] = 10; plen[k] = 4; end
            6: begin path[k][2] = 11; plen[k] = 3; end
            default: ;
        endcase
    endtask

    logic [17:0] obs_ctrl  [2];
    logic [3:0]  obs_state [2];
    logic [31:0] obs_cnt   [2];
    int          rst_left;

    initial begin
        for (int k = 0; k < 2; k++) begin
            path[k][0] = 0;
            path[k][1] = 1;
            plen[k] = 2;
            pidx[k] = 0;
            cnt[k] = 0;
        end
        mask[0] = 32'h0000_FFFF;
        mask[1] = 32'h0000_000F;
        en_addi[0] = 1'b1; en_j[0] = 1'b1;
        en_addi[1] = 1'b0; en_j[1] = 1'b0;

        rst = 1'b1;
        op = 6'd0;
        funct = 6'd0;
        mem_ready = 1'b1;
        rst_left = 2;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            if (rst_left > 0) begin
                rst_left--;
            end else if ((path[0][pidx[0]] == 3 && $urandom_range(0, 9) == 0) ||
                         $urandom_range(0, 399) == 0) begin
                rst_left = $urandom_range(0, 1);
            end else begin
                rst_left = -1;
            end
            rst = (rst_left >= 0);
            case ($urandom_range(0, 7))
                0, 7:    op = 6'b000000;
                1:       op = 6'b100011;
                2:       op = 6'b101011;
                3:       op = 6'b000100;
                4:       op = 6'b001000;
                5:       op = 6'b000010;
                default: op = 6'($urandom);
            endcase
            funct = 6'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0);

            @(negedge clk);
            obs_ctrl[0] = {bus_a.IorD, bus_a.Mem_RE, bus_a.DM_WE, bus_a.IR_WE, bus_a.PC_WE,
                           bus_a.Branch, bus_a.Reg_WE, bus_a.REG_Dst, bus_a.MEM_to_REG,
                           bus_a.ALU_srcA, bus_a.ALU_srcB, bus_a.ALU_OP, bus_a.PC_src,
                           bus_a.illegal, bus_a.retire};
            obs_ctrl[1] = {bus_b.IorD, bus_b.Mem_RE, bus_b.DM_WE, bus_b.IR_WE, bus_b.PC_WE,
                           bus_b.Branch, bus_b.Reg_WE, bus_b.REG_Dst, bus_b.MEM_to_REG,
                           bus_b.ALU_srcA, bus_b.ALU_srcB, bus_b.ALU_OP, bus_b.PC_src,
                           bus_b.illegal, bus_b.retire};
            obs_state[0] = bus_a.state;
            obs_state[1] = bus_b.state;
            obs_cnt[0] = 32'(bus_a.instr_cnt);
            obs_cnt[1] = 32'(bus_b.instr_cnt);

            for (int k = 0; k < 2; k++) begin
                int          s;
                int          c;
                logic [17:0] e;
                s = rst ? 0 : path[k][pidx[k]];
                c = classify(op, funct, en_addi[k], en_j[k]);
                e = exp_ctrl(s, mem_ready, (s == 1) && (c == 0), rst);
                check($sformatf("dut%0d state", k), 32'(obs_state[k]), 32'(s));
                check($sformatf("dut%0d ctrl st%0d", k, s), 32'(obs_ctrl[k]), 32'(e));
                check($sformatf("dut%0d instr_cnt", k), obs_cnt[k], rst ? 32'd0 : cnt[k]);

                if (rst) begin
                    pidx[k] = 0;
                    plen[k] = 2;
                    cnt[k] = 0;
                end else begin
                    if (e[0]) cnt[k] = (cnt[k] + 1) & mask[k];
                    if ((s == 0 || s == 3 || s == 5) && !mem_ready) begin
                        // memory stall: stay put
                    end else if (s == 1) begin
                        if (c == 0) begin
                            pidx[k] = 0;
                            plen[k] = 2;
                        end else begin
                            set_path(k, c);
                            pidx[k] = 2;
                        end
                    end else begin
                        pidx[k]++;
                        if (pidx[k] >= plen[k]) pidx[k] = 0;
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
